// File: rtl/pim_pkg.sv
// ---------------------------------------------------------------------------
// pim_pkg
// Shared definitions for the PIM memory and matrix-multiply engine blocks.
//   - PIM_WIDTH / PIM_N / PIM_NUM_PIMS : default element width, matrix
//     dimension and physical MAC lane count
//   - pim_state_e                      : engine FSM state encoding
//   - acc_width()                      : accumulator width that cannot
//                                        overflow for an N-term dot product
// ---------------------------------------------------------------------------
package pim_pkg;

    localparam int PIM_WIDTH    = 16;
    localparam int PIM_N        = 4;
    localparam int PIM_NUM_PIMS = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } pim_state_e;

    // Full-precision product plus enough headroom for N additions.
    function automatic int acc_width(input int width, input int n);
        return 2 * width + $clog2(n);
    endfunction

endpackage

// File: rtl/pim_mac_lane.sv
// ---------------------------------------------------------------------------
// pim_mac_lane
// One signed multiply-accumulate lane.
//   clk, rst : clock, synchronous active-high reset
//   en       : add the current product into the accumulator
//   clr      : clear the accumulator (wins over en)
//   i_a, i_b : signed WIDTH-bit operands
//   o_prod   : combinational 2*WIDTH-bit signed product
//   o_acc    : registered ACC_W-bit signed accumulator
// ---------------------------------------------------------------------------
module pim_mac_lane
    import pim_pkg::*;
#(
    parameter int WIDTH = PIM_WIDTH,
    parameter int ACC_W = acc_width(PIM_WIDTH, PIM_N)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    clr,
    input  logic signed [WIDTH-1:0] i_a,
    input  logic signed [WIDTH-1:0] i_b,
    output logic signed [2*WIDTH-1:0] o_prod,
    output logic signed [ACC_W-1:0] o_acc
);

    logic signed [ACC_W-1:0] r_acc;

    assign o_prod = i_a * i_b;
    assign o_acc  = r_acc;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_acc <= '0;
        end else if (en) begin
            r_acc <= r_acc + {{(ACC_W-2*WIDTH){o_prod[2*WIDTH-1]}}, o_prod};
        end
    end

endmodule

// File: rtl/pim_matmul_engine.sv
// ---------------------------------------------------------------------------
// pim_matmul_engine
// Computes C = A x B for flattened row-major N x N signed matrices using up
// to NUM_PIMS parallel MAC lanes. Each batch of N cycles produces P output
// elements; the result is offered until the consumer accepts it.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid / in_ready   : job handshake (in_a, in_b, active_pims)
//   active_pims           : lane count, 0 -> 1, above NUM_PIMS -> NUM_PIMS
//   out_valid / out_ready : result handshake (out_c)
//   busy                  : engine is computing or holding a result
// Build option: define PIM_SAT_EN to saturate C elements instead of wrapping.
// ---------------------------------------------------------------------------
module pim_matmul_engine
    import pim_pkg::*;
#(
    parameter int WIDTH    = PIM_WIDTH,
    parameter int N        = PIM_N,
    parameter int NUM_PIMS = PIM_NUM_PIMS
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [N*N*WIDTH-1:0]           in_a,
    input  logic [N*N*WIDTH-1:0]           in_b,
    input  logic [$clog2(NUM_PIMS+1)-1:0]  active_pims,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [N*N*WIDTH-1:0]           out_c,
    output logic                           busy
);

    localparam int ACC_W = acc_width(WIDTH, N);
    localparam int NN    = N * N;
    localparam int PW    = $clog2(NUM_PIMS + 1);
    localparam int EW    = $clog2(NN + NUM_PIMS + 1);
    localparam int KW    = $clog2(N);

    localparam logic [1:0] ST_IDLE    = IDLE;
    localparam logic [1:0] ST_COMPUTE = COMPUTE;
    localparam logic [1:0] ST_DONE    = DONE;

    logic [1:0]             r_state;
    logic [NN*WIDTH-1:0]    r_a;
    logic [NN*WIDTH-1:0]    r_b;
    logic [NN*WIDTH-1:0]    r_c;
    logic [PW-1:0]          r_p;
    logic [EW-1:0]          r_base;
    logic [KW-1:0]          r_k;

    logic                   w_last_k;
    logic [PW-1:0]          w_p_clamped;
    logic [EW-1:0]          w_next_base;

    logic [EW-1:0]                w_e    [NUM_PIMS];
    logic                         w_vld  [NUM_PIMS];
    logic signed [2*WIDTH-1:0]    w_prod [NUM_PIMS];
    logic signed [ACC_W-1:0]      w_acc  [NUM_PIMS];
    logic signed [ACC_W-1:0]      w_sum  [NUM_PIMS];
    logic [WIDTH-1:0]             w_res  [NUM_PIMS];

    assign w_last_k    = (r_k == KW'(N - 1));
    assign w_next_base = r_base + EW'(r_p);

    always_comb begin
        w_p_clamped = active_pims;
        if (active_pims == '0) begin
            w_p_clamped = PW'(1);
        end else if (int'(active_pims) > NUM_PIMS) begin
            w_p_clamped = PW'(NUM_PIMS);
        end
    end

`ifdef PIM_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
`endif

    for (genvar l = 0; l < NUM_PIMS; l++) begin : g_lane
        logic [EW-1:0] w_ai;
        logic [EW-1:0] w_bi;

        assign w_e[l]   = r_base + EW'(l);
        // Lanes beyond P, or past the last element in the final batch, idle.
        assign w_vld[l] = (r_state == ST_COMPUTE) && (l < int'(r_p)) && (w_e[l] < EW'(NN));

        // A[i][k] sits at i*N+k, B[k][j] at k*N+j, with i = e/N and j = e%N.
        assign w_ai = w_vld[l] ? ((w_e[l] / EW'(N)) * EW'(N) + EW'(r_k)) : '0;
        assign w_bi = w_vld[l] ? (EW'(r_k) * EW'(N) + (w_e[l] % EW'(N))) : '0;

        pim_mac_lane #(
            .WIDTH (WIDTH),
            .ACC_W (ACC_W)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .en     (w_vld[l]),
            .clr    (w_vld[l] && w_last_k),
            .i_a    (r_a[int'(w_ai)*WIDTH +: WIDTH]),
            .i_b    (r_b[int'(w_bi)*WIDTH +: WIDTH]),
            .o_prod (w_prod[l]),
            .o_acc  (w_acc[l])
        );

        // Final element value: the stored partial sum plus this cycle's product.
        assign w_sum[l] = w_acc[l] + {{(ACC_W-2*WIDTH){w_prod[l][2*WIDTH-1]}}, w_prod[l]};

`ifdef PIM_SAT_EN
        assign w_res[l] = (w_sum[l] > SAT_MAX) ? SAT_MAX[WIDTH-1:0] :
                          (w_sum[l] < SAT_MIN) ? SAT_MIN[WIDTH-1:0] :
                                                 w_sum[l][WIDTH-1:0];
`else
        assign w_res[l] = w_sum[l][WIDTH-1:0];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_base  <= '0;
            r_k     <= '0;
            r_p     <= PW'(1);
            r_a     <= '0;
            r_b     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a     <= in_a;
                        r_b     <= in_b;
                        r_p     <= w_p_clamped;
                        r_base  <= '0;
                        r_k     <= '0;
                        r_state <= ST_COMPUTE;
                    end
                end
                ST_COMPUTE: begin
                    if (w_last_k) begin
                        r_k    <= '0;
                        r_base <= w_next_base;
                        if (w_next_base >= EW'(NN)) begin
                            r_state <= ST_DONE;
                        end
                    end else begin
                        r_k <= r_k + KW'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_c <= '0;
        end else if (w_last_k) begin
            for (int l = 0; l < NUM_PIMS; l++) begin
                if (w_vld[l]) begin
                    r_c[int'(w_e[l])*WIDTH +: WIDTH] <= w_res[l];
                end
            end
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);
    assign out_c     = r_c;

endmodule
